// File: rtl/collision_pkg.sv
// ============================================================================
// collision_pkg : shared FSM state encoding and default sizing constants
// Revision 1.0
// ============================================================================
`default_nettype none

package collision_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_e;

  localparam int unsigned DEF_N_CH     = 4;
  localparam int unsigned DEF_DEBOUNCE = 16;
  localparam int unsigned DEF_CNT_SAT  = 255;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/collision_debounce_ch.sv
// ============================================================================
// collision_debounce_ch : per-channel overlap debounce counter and hit strobe
// Revision 1.0
// ============================================================================
`default_nettype none

module collision_debounce_ch
  import collision_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clock_100mhz,
  input  logic reset,
  input  logic clear,
  input  logic overlap,
  output logic hit
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] C_MAX  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // The counter parks at C_MAX during a long overlap, so the strobe fires once
  // and the channel only re-arms after a non-overlap cycle zeroes it.
  always_comb begin
    count_d = count_q;
    hit     = 1'b0;
    if (clear || !overlap) begin
      count_d = '0;
    end else if (count_q != C_MAX) begin
      count_d = count_q + CW'(1);
      hit     = (count_q == C_LAST);
    end
  end

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/collision_monitor.sv
// ============================================================================
// collision_monitor : debounced player/obstacle overlap detector with latched
//                     hit mask, first-hit channel and saturating hit count
// Revision 1.0
// ============================================================================
`default_nettype none

module collision_monitor
  import collision_pkg::*;
#(
  parameter  int unsigned N_CH     = DEF_N_CH,
  parameter  int unsigned DEBOUNCE = DEF_DEBOUNCE,
  parameter  int unsigned CNT_SAT  = DEF_CNT_SAT,
  localparam int unsigned CH_W     = ch_idx_w(N_CH)
) (
  input  logic            clock_100mhz,
  input  logic            reset,
  input  logic            game_active,
  input  logic            is_player_hitbox,
  input  logic [N_CH-1:0] is_obstacle_hitbox,
  input  logic            clear_ack,
  output logic            is_collision,
  output logic            collision_pulse,
  output logic [N_CH-1:0] hit_mask,
  output logic [CH_W-1:0] first_hit_ch,
  output logic [7:0]      hit_count
);

  localparam logic [8:0] C_SAT = 9'(CNT_SAT);

  state_e          state_q, state_d;
  logic            pulse_q, pulse_d;
  logic [N_CH-1:0] hit_mask_q, hit_mask_d;
  logic [CH_W-1:0] first_q, first_d;
  logic [7:0]      hit_count_q, hit_count_d;

  logic [N_CH-1:0] w_overlap;
  logic [N_CH-1:0] w_hits;
  logic            w_any_hit;
  logic            w_ch_clear;
  logic [CH_W-1:0] w_lowest;
  logic [4:0]      w_pop;
  logic [8:0]      w_sum;
  logic [7:0]      w_count_inc;

  assign w_overlap = {N_CH{is_player_hitbox}} & is_obstacle_hitbox;
  // Counters only run while a round is armed or holding a hit.
  assign w_ch_clear = !game_active || (state_q == IDLE);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    collision_debounce_ch #(
      .DEBOUNCE (DEBOUNCE)
    ) u_ch (
      .clock_100mhz (clock_100mhz),
      .reset        (reset),
      .clear        (w_ch_clear),
      .overlap      (w_overlap[g]),
      .hit          (w_hits[g])
    );
  end

  assign w_any_hit = |w_hits;

  always_comb begin
    w_lowest = '0;
    w_pop    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_hits[i]) begin
        w_lowest = CH_W'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      w_pop = w_pop + 5'(w_hits[i]);
    end
    w_sum       = {1'b0, hit_count_q} + 9'(w_pop);
    w_count_inc = (w_sum > C_SAT) ? C_SAT[7:0] : w_sum[7:0];
  end

  always_comb begin
    state_d     = state_q;
    pulse_d     = 1'b0;
    hit_mask_d  = hit_mask_q;
    first_d     = first_q;
    hit_count_d = hit_count_q;
    if (!game_active) begin
      state_d     = IDLE;
      hit_mask_d  = '0;
      first_d     = '0;
      hit_count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (w_any_hit) begin
            state_d     = HIT;
            pulse_d     = 1'b1;
            hit_mask_d  = w_hits;
            first_d     = w_lowest;
            hit_count_d = w_count_inc;
          end
        end
        HIT: begin
          if (w_any_hit) begin
            hit_count_d = w_count_inc;
            // An acknowledge coinciding with a fresh hit restarts the latch.
            if (clear_ack) begin
              pulse_d    = 1'b1;
              hit_mask_d = w_hits;
              first_d    = w_lowest;
            end else begin
              hit_mask_d = hit_mask_q | w_hits;
            end
          end else if (clear_ack) begin
            state_d    = ARMED;
            hit_mask_d = '0;
            first_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      state_q     <= IDLE;
      pulse_q     <= 1'b0;
      hit_mask_q  <= '0;
      first_q     <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      hit_mask_q  <= hit_mask_d;
      first_q     <= first_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign is_collision    = (state_q == HIT);
  assign collision_pulse = pulse_q;
  assign hit_mask        = hit_mask_q;
  assign first_hit_ch    = first_q;
  assign hit_count       = hit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_collision_monitor.sv
// ============================================================================
// tb_collision_monitor : directed vector bench for collision_monitor
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_collision_monitor;

  logic       clk = 1'b0;
  logic       rst, ga, ply, clr;
  logic [3:0] obs;
  logic       col, pls;
  logic [3:0] mask;
  logic [1:0] first;
  logic [7:0] cnt;

  logic       rst1, ga1, ply1, clr1;
  logic [3:0] obs1;
  logic       col1, pls1;
  logic [3:0] mask1;
  logic [1:0] first1;
  logic [7:0] cnt1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  collision_monitor #(.N_CH(4), .DEBOUNCE(16), .CNT_SAT(255)) dut (
    .clock_100mhz       (clk),
    .reset              (rst),
    .game_active        (ga),
    .is_player_hitbox   (ply),
    .is_obstacle_hitbox (obs),
    .clear_ack          (clr),
    .is_collision       (col),
    .collision_pulse    (pls),
    .hit_mask           (mask),
    .first_hit_ch       (first),
    .hit_count          (cnt)
  );

  collision_monitor #(.N_CH(4), .DEBOUNCE(1), .CNT_SAT(255)) dut1 (
    .clock_100mhz       (clk),
    .reset              (rst1),
    .game_active        (ga1),
    .is_player_hitbox   (ply1),
    .is_obstacle_hitbox (obs1),
    .clear_ack          (clr1),
    .is_collision       (col1),
    .collision_pulse    (pls1),
    .hit_mask           (mask1),
    .first_hit_ch       (first1),
    .hit_count          (cnt1)
  );

  typedef struct {
    string      name;
    int         reps;
    logic       rst, ga, ply;
    logic [3:0] obs;
    logic       clr;
    logic [15:0] exp;  // {is_collision, pulse, hit_mask, first_hit_ch, hit_count}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input int reps, input logic r, input logic g,
                              input logic p, input logic [3:0] o, input logic c,
                              input logic ec, input logic ep, input logic [3:0] em,
                              input logic [1:0] ef, input logic [7:0] en);
    vec_t v;
    v.name = nm; v.reps = reps; v.rst = r; v.ga = g; v.ply = p; v.obs = o; v.clr = c;
    v.exp  = {ec, ep, em, ef, en};
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    rst = 1'b1; ga = 1'b0; ply = 1'b0; obs = 4'h0; clr = 1'b0;
    rst1 = 1'b1; ga1 = 1'b0; ply1 = 1'b0; obs1 = 4'h0; clr1 = 1'b0;

    //                 name          reps rst ga ply obs   clr  col pls mask  fst  cnt
    tbl.push_back(mk("reset",         2, 1, 0, 0, 4'h0, 0,   0, 0, 4'h0, 0, 8'd0));
    tbl.push_back(mk("arm",           1, 0, 1, 0, 4'h0, 0,   0, 0, 4'h0, 0, 8'd0));
    tbl.push_back(mk("ch2_15cyc",    15, 0, 1, 1, 4'h4, 0,   0, 0, 4'h0, 0, 8'd0));
    tbl.push_back(mk("ch2_16cyc",     1, 0, 1, 1, 4'h4, 0,   1, 1, 4'h4, 2, 8'd1));
    tbl.push_back(mk("ch2_hold",      5, 0, 1, 1, 4'h4, 0,   1, 0, 4'h4, 2, 8'd1));
    tbl.push_back(mk("clear",         1, 0, 1, 0, 4'h4, 1,   0, 0, 4'h0, 0, 8'd1));
    tbl.push_back(mk("ch1_run1",     10, 0, 1, 1, 4'h2, 0,   0, 0, 4'h0, 0, 8'd1));
    tbl.push_back(mk("ch1_gap",       1, 0, 1, 1, 4'h0, 0,   0, 0, 4'h0, 0, 8'd1));
    tbl.push_back(mk("ch1_run2",     10, 0, 1, 1, 4'h2, 0,   0, 0, 4'h0, 0, 8'd1));
    tbl.push_back(mk("ch1_run2_15",   5, 0, 1, 1, 4'h2, 0,   0, 0, 4'h0, 0, 8'd1));
    tbl.push_back(mk("ch1_run2_16",   1, 0, 1, 1, 4'h2, 0,   1, 1, 4'h2, 1, 8'd2));
    tbl.push_back(mk("clear2",        1, 0, 1, 0, 4'h0, 1,   0, 0, 4'h0, 0, 8'd2));
    tbl.push_back(mk("ch0_ch3_same", 16, 0, 1, 1, 4'h9, 0,   1, 1, 4'h9, 0, 8'd4));
    tbl.push_back(mk("ch0_ch3_hold",  1, 0, 1, 1, 4'h9, 0,   1, 0, 4'h9, 0, 8'd4));
    tbl.push_back(mk("ch1_pre",      15, 0, 1, 1, 4'h2, 0,   1, 0, 4'h9, 0, 8'd4));
    tbl.push_back(mk("ack_with_hit",  1, 0, 1, 1, 4'h2, 1,   1, 1, 4'h2, 1, 8'd5));
    tbl.push_back(mk("or_in_hit",    16, 0, 1, 1, 4'h6, 0,   1, 0, 4'h6, 1, 8'd6));
    tbl.push_back(mk("game_off",      1, 0, 0, 1, 4'h6, 0,   0, 0, 4'h0, 0, 8'd0));
    tbl.push_back(mk("rearm",         1, 0, 1, 0, 4'h0, 0,   0, 0, 4'h0, 0, 8'd0));
    tbl.push_back(mk("ch0_12_ack",   12, 0, 1, 1, 4'h1, 1,   0, 0, 4'h0, 0, 8'd0));
    tbl.push_back(mk("reset_mid",     1, 1, 1, 1, 4'h1, 0,   0, 0, 4'h0, 0, 8'd0));
    tbl.push_back(mk("post_rst_15",  16, 0, 1, 1, 4'h1, 0,   0, 0, 4'h0, 0, 8'd0));
    tbl.push_back(mk("post_rst_16",   1, 0, 1, 1, 4'h1, 0,   1, 1, 4'h1, 0, 8'd1));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; ga = tbl[i].ga; ply = tbl[i].ply; obs = tbl[i].obs; clr = tbl[i].clr;
      repeat (tbl[i].reps) @(posedge clk);
      #1;
      check(tbl[i].name, {col, pls, mask, first, cnt}, tbl[i].exp);
    end

    // Saturation with one-cycle debounce: 300 isolated overlaps, one of them
    // on all four channels at once to push the sum past the ceiling.
    repeat (2) @(posedge clk);
    rst1 = 1'b0; ga1 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 300; k++) begin
      ply1 = 1'b1;
      obs1 = (k == 254) ? 4'hF : 4'h1;
      @(posedge clk); #1;
      if (k == 1)   check("sat_first",  {col1, pls1, mask1, first1, cnt1}, {1'b1, 1'b1, 4'h1, 2'd0, 8'd1});
      if (k == 2)   check("sat_second", {col1, pls1, mask1, first1, cnt1}, {1'b1, 1'b0, 4'h1, 2'd0, 8'd2});
      if (k == 253) check("sat_253",    {8'd0, cnt1}, {8'd0, 8'd253});
      if (k == 254) check("sat_multi",  {col1, pls1, mask1, first1, cnt1}, {1'b1, 1'b0, 4'hF, 2'd0, 8'd255});
      if (k == 300) check("sat_300",    {8'd0, cnt1}, {8'd0, 8'd255});
      ply1 = 1'b0;
      obs1 = 4'h0;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/collision_monitor.md
COLLISION_MONITOR -- requirements
Module: collision_monitor

Interface
REQ-001 Parameter N_CH, default 4, number of obstacle hitbox channels (1..16).
REQ-002 Parameter DEBOUNCE, default 16, consecutive overlap cycles required to register a hit (1..256).
REQ-003 Parameter CNT_SAT, default 255, saturation value of hit_count (<=255).
REQ-004 clock_100mhz  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 game_active  in  1  high while a round runs; low clears the block.
REQ-007 is_player_hitbox  in  1  current pixel inside player hitbox.
REQ-008 is_obstacle_hitbox  in  N_CH  per-channel: current pixel inside obstacle i hitbox.
REQ-009 clear_ack  in  1  one-cycle request to clear the latched collision.
REQ-010 is_collision  out  1  level flag; high while any unacknowledged hit is held.
REQ-011 collision_pulse  out  1  one-cycle strobe on the ARMED->HIT transition.
REQ-012 hit_mask  out  N_CH  bit i set when channel i registered a hit since last clear.
REQ-013 first_hit_ch  out  max(1,clog2(N_CH))  index of the channel that caused the ARMED->HIT transition.
REQ-014 hit_count  out  8  saturating count of registered hit events in the current round.

Function
REQ-015 Overlap_i SHALL be is_player_hitbox AND is_obstacle_hitbox[i], sampled every cycle.
REQ-016 Each channel SHALL hold a counter, width clog2(DEBOUNCE+1): +1 per cycle of overlap_i, saturating at DEBOUNCE; reset to 0 on any cycle without overlap_i.
REQ-017 Channel i SHALL register a hit at the edge where its counter advances to DEBOUNCE, i.e. after exactly DEBOUNCE consecutive overlap cycles; outputs update the following cycle.
REQ-018 A channel SHALL register at most one hit per continuous overlap; it re-arms only after its counter returns to 0.
REQ-019 FSM states: IDLE (game_active=0), ARMED (no held hit), HIT (hit held).
REQ-020 IDLE->ARMED when game_active=1; any state->IDLE when game_active=0.
REQ-021 ARMED->HIT on any registered hit; collision_pulse=1 for that single cycle; first_hit_ch latched.
REQ-022 HIT->ARMED on clear_ack=1 with no new hit that cycle; clears is_collision, hit_mask and first_hit_ch.
REQ-023 clear_ack together with a new hit: state stays HIT; hit_mask becomes only the new hit bits; first_hit_ch becomes the lowest new index; collision_pulse=1.
REQ-024 clear_ack in IDLE or ARMED SHALL be ignored.
REQ-025 Hits in HIT state SHALL OR into hit_mask, increment hit_count, leave first_hit_ch unchanged, and produce no collision_pulse.
REQ-026 Simultaneous hits on several channels: all bits set; first_hit_ch = lowest index; hit_count += number of hitting channels, saturating at CNT_SAT.
REQ-027 is_collision SHALL equal (state==HIT), registered.
REQ-028 Entering IDLE SHALL clear all counters, hit_mask, first_hit_ch, hit_count, is_collision and collision_pulse on the same edge.

Reset
REQ-029 reset=1 SHALL force state IDLE and every output and counter to 0 at the next edge, overriding all other inputs.
REQ-030 Reset mid-debounce or in HIT SHALL discard partial counts; no hit registers from pre-reset overlap.

Structure
REQ-031 Package collision_pkg SHALL hold the FSM state enum (IDLE, ARMED, HIT) and default parameter constants.
REQ-032 Sub-module collision_debounce_ch SHALL implement one channel counter and hit strobe (REQ-016..018), instantiated N_CH times via generate.

Verification
REQ-033 N_CH=4, DEBOUNCE=16: overlap ch2 for 16 cycles -> pulse once, is_collision=1, hit_mask=0100, first_hit_ch=2, hit_count=1; at 15 cycles -> no hit.
REQ-034 Overlap ch1 for 10 cycles, gap 1 cycle, 10 cycles -> no hit (counter restarts).
REQ-035 Ch0 and ch3 reach DEBOUNCE on the same edge -> hit_mask=1001, first_hit_ch=0, hit_count=2, one pulse.
REQ-036 In HIT, clear_ack on the edge where ch1 hits -> stays HIT, hit_mask=0010, first_hit_ch=1, pulse=1.
REQ-037 In HIT, game_active low 1 cycle -> all outputs 0, IDLE; reset asserted at debounce count 12 -> no hit after release.
REQ-038 DEBOUNCE=1, CNT_SAT=255: 300 separate single-cycle overlaps -> hit_count saturates at 255.
